// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_row.sv
// One row of WIDTH multiplier cells: AND partial product plus ppi, rippled carry.
module mult_row #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] m,
  input  logic             q_bit,
  input  logic [WIDTH-1:0] ppi,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  always_comb begin
    carry[0] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      sum[k]       = ppi[k] ^ (m[k] & q_bit) ^ carry[k];
      carry[k + 1] = (ppi[k] & (m[k] & q_bit)) | (ppi[k] & carry[k])
                   | ((m[k] & q_bit) & carry[k]);
    end
    cout = carry[WIDTH];
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller reusing one mult_row over WIDTH cycles.
// Optional SEQ_MULT_ZERO_SKIP_EN: zero operands finish immediately without RUN.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e                 state_q, state_d;
  logic   [WIDTH-1:0]     m_q, m_d;
  logic   [WIDTH-1:0]     hi_q, hi_d;
  logic   [WIDTH-1:0]     lo_q, lo_d;
  logic   [CntW-1:0]      cnt_q, cnt_d;
  logic   [2*WIDTH-1:0]   product_q, product_d;

  logic                   accept;
  logic                   last;
  logic                   zero_op;
  logic   [WIDTH-1:0]     row_sum;
  logic                   row_cout;

  assign accept = start && (state_q != StRun);
  assign last   = (cnt_q == CntW'(WIDTH - 1));

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign zero_op = (m == '0) || (q == '0);
`else
  assign zero_op = 1'b0;
`endif

  mult_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .m    (m_q),
    .q_bit(lo_q[0]),
    .ppi  (hi_q),
    .sum  (row_sum),
    .cout (row_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = zero_op ? StDone : StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = accept ? (zero_op ? StDone : StRun) : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      m_d   = m;
      hi_d  = '0;
      lo_d  = q;
      cnt_d = '0;
      if (zero_op) product_d = '0;
    end else if (state_q == StRun) begin
      hi_d  = {row_cout, row_sum[WIDTH-1:1]};
      lo_d  = {row_sum[0], lo_q[WIDTH-1:1]};
      // Hold at the final count so narrow counters never wrap.
      cnt_d = last ? cnt_q : cnt_q + CntW'(1);
      if (last) product_d = {hi_d, lo_d};
    end
  end

  always_comb begin
    ready = 1'b1;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StRun:   begin
        ready = 1'b0;
        busy  = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: stimulus pushes expected product and done cycle.
module tb_seq_mult_ctrl;

  localparam int unsigned W = 4;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   m = '0;
  logic [W-1:0]   q = '0;
  logic           ready, busy, done;
  logic [2*W-1:0] product;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   pushed = 0;
  exp_t exp_q[$];

  seq_mult_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .m      (m),
    .q      (q),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("product", 32'(product), 32'(e.prod));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Caller must be at a negedge; returns just after the accepting edge.
  task automatic do_start(input logic [W-1:0] mm, input logic [W-1:0] qq,
                          input bit push, input logic [2*W-1:0] prod);
    int lat;
    exp_t e;
    lat = W;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    if (mm == '0 || qq == '0) lat = 0;
`endif
    start = 1'b1;
    m     = mm;
    q     = qq;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.prod = prod;
      e.cyc  = cyc + lat;
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 40);
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'(1));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'(1));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_product", 32'(product), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // 15 x 15: busy for exactly W cycles, then the result holds.
    do_start(4'hF, 4'hF, 1'b1, 8'hE1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("run_busy", 32'(busy), 32'(1));
      check("run_ready", 32'(ready), 32'(0));
    end
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_product", 32'(product), 32'(8'hE1));
    check("hold_ready", 32'(ready), 32'(1));
    check("hold_done", 32'(done), 32'(0));

    // 3 x 5 then an immediate restart from DONE with 9 x 7.
    do_start(4'd3, 4'd5, 1'b1, 8'd15);
    wait_done();
    do_start(4'd9, 4'd7, 1'b1, 8'd63);
    check("restart_done_fell", 32'(done), 32'(0));
    check("restart_busy", 32'(busy), 32'(1));
    wait_done();
    @(negedge clk);

    // Start during RUN is ignored.
    do_start(4'd6, 4'd6, 1'b1, 8'd36);
    @(negedge clk);
    start = 1'b1;
    m     = 4'd1;
    q     = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);

    // Reset mid-RUN: no done pulse and product cleared.
    do_start(4'd7, 4'd7, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(ready), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_product", 32'(product), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    do_start(4'd2, 4'd3, 1'b1, 8'd6);
    wait_done();
    @(negedge clk);

    // Zero operand: latency depends on SEQ_MULT_ZERO_SKIP_EN.
    do_start(4'd0, 4'd9, 1'b1, 8'd0);
    wait_done();
    repeat (3) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("done_pulses", 32'(done_count), 32'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Sequential shift-add multiplier controller for the multiplier library. It time-multiplexes one row of WIDTH multiplier cells over WIDTH clock cycles instead of instantiating a full WIDTH×WIDTH array. It handles operand capture, iteration counting, accumulator shifting and the start/done handshake. Each cell computes an AND partial-product bit plus ppi and cin, giving sum and cout.

## Interface
- WIDTH, 4, operand width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- m  input  WIDTH  multiplicand, captured on accepted start.
- q  input  WIDTH  multiplier, captured on accepted start.
- ready  output  1  high in IDLE and DONE; a start is accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  unsigned m×q; held until the next accepted start.

## Operation
- States:
  - IDLE: ready=1, busy=0, done=0.
  - RUN: ready=0, busy=1, done=0.
  - DONE: ready=1, busy=0, done=1.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE when the iteration count reaches WIDTH−1 at an edge.
  - DONE→RUN on start.
  - DONE→IDLE otherwise.
- Accepted start:
  - m_reg←m; acc_lo←q; acc_hi←0; cnt←0.
  - product is not cleared.
- Each RUN cycle:
  - The row computes {cout, sum} = acc_hi + (m_reg & {WIDTH{acc_lo[0]}}), WIDTH+1 bits with an unsigned carry chain.
  - acc_hi←{cout, sum[WIDTH−1:1]}; acc_lo←{sum[0], acc_lo[WIDTH−1:1]}; cnt←cnt+1.
- On the RUN→DONE edge, product←{final acc_hi, final acc_lo}. This is exact; no overflow is possible.
- start while in RUN is ignored, with no queueing.
- cnt is $clog2(WIDTH) bits wide and does not wrap within an operation.
- Reset:
  - rst=1 at any edge, including mid-RUN, forces IDLE.
  - It clears m_reg, acc, cnt and product to 0.
  - It forces ready=1, busy=0, done=0.
  - rst has priority over start.

## Timing
- Reset values: ready=1, busy=0, done=0, product=0.
- Start sampled at edge E0:
  - busy=1 after E0.
  - done=1 and product valid after edge E_WIDTH; for WIDTH=4, that is 5 edges from E0 inclusive.
- done is high for exactly one cycle unless another start arrives during DONE. In that case done falls and busy rises after the same edge.
- Back-to-back throughput: one result every WIDTH+1 cycles.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- SEQ_MULT_ZERO_SKIP_EN
  - Defined: an accepted start with m==0 or q==0 goes directly to DONE. product←0 and done=1 after E0+1 edge; RUN is skipped.
  - Undefined: every operation takes the full WIDTH RUN cycles.
- Results are identical either way; only the latency differs.

## Structure
- Package seq_mult_pkg:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - Count-width function.
- Sub-module mult_row (WIDTH, m, q_bit, ppi[WIDTH], sum[WIDTH], cout):
  - Purely combinational: a ripple chain of WIDTH multiplier cells.
  - cell k: ppi[k], AND m[k]&q_bit, carry in from k−1.
- seq_mult_ctrl holds only the FSM, the counter and the registers.

## Test plan
- Reset: hold rst for 2 cycles. Expect ready=1, busy=0, done=0, product=0.
- m=4'hF, q=4'hF, start for 1 cycle. Expect busy for 4 cycles, then done=1 with product=8'hE1; product holds 8'hE1 afterwards.
- m=4'd3, q=4'd5 → product=8'd15. Immediately restart from DONE with m=4'd9, q=4'd7 → product=8'd63 after a further 5 edges; done falls between the two results.
- Assert start with m=1, q=1 during RUN of 4'd6×4'd6. Expect it ignored; product=8'd36 and only one done pulse.
- Assert rst mid-RUN at cycle 2. Expect IDLE on the next edge with product=0 and no done pulse. A following 2×3 gives 8'd6.
- m=0, q=4'd9:
  - Macro defined: done after 1 edge, product=0.
  - Macro undefined: done after 5 edges, product=0.
